// File: rtl/stream_packet_fifo.sv
// -----------------------------------------------------------------------------
// stream_packet_fifo
//
// Store-and-forward packet buffer that sits after the QoS stream arbiter.
// Beats ({data, qos, id, last}) are held until a whole packet (its last beat)
// is in the buffer, so the consumer never sees a packet stall halfway through.
// A packet longer than DEPTH would otherwise deadlock: when the buffer is full
// and holds no complete packet, the head is released and the FSM stays in
// cut-through until that packet's last beat has been read.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   s_*_in             input beat: data, qos, id, last, valid
//   s_ready_out        buffer can take a beat (depends only on the stored count)
//   m_*_out            head beat, first-word fall-through; zero while invalid
//   m_valid_out        head beat may be transferred
//   m_ready_in         consumer ready
//   count_out          beats stored
//   pkt_count_out      complete packets stored (last beats in the buffer)
// -----------------------------------------------------------------------------
module stream_packet_fifo #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_QOS__WIDTH = 2,
    parameter int STREAM_COUNT = 3,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
    parameter int DEPTH        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [T_DATA_WIDTH-1:0]   s_data_in,
    input  logic [T_QOS__WIDTH-1:0]   s_qos_in,
    input  logic [T_ID___WIDTH-1:0]   s_id_in,
    input  logic                      s_last_in,
    input  logic                      s_valid_in,
    output logic                      s_ready_out,
    output logic [T_DATA_WIDTH-1:0]   m_data_out,
    output logic [T_QOS__WIDTH-1:0]   m_qos_out,
    output logic [T_ID___WIDTH-1:0]   m_id_out,
    output logic                      m_last_out,
    output logic                      m_valid_out,
    input  logic                      m_ready_in,
    output logic [$clog2(DEPTH):0]    count_out,
    output logic [$clog2(DEPTH):0]    pkt_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_QOS__WIDTH-1:0] qos;
        logic [T_ID___WIDTH-1:0] id;
        logic                    last;
    } beat_t;

    typedef enum logic {
        ST_STORE = 1'b0,
        ST_CUT   = 1'b1
    } state_t;

    beat_t           mem_q [DEPTH];
    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   pkt_count_q, pkt_count_d;
    state_t          state_q, state_d;

    beat_t           beat_in;
    beat_t           head;
    logic            full;
    logic            empty;
    logic            wr;
    logic            rd;
    logic            valid;

    assign beat_in = '{data: s_data_in, qos: s_qos_in, id: s_id_in, last: s_last_in};
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    assign full  = (count_q == CW'(DEPTH));
    // Pointers carry a wrap bit, so equal pointers mean empty; this always
    // agrees with count_q == 0.
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign s_ready_out = !full;
    assign wr          = s_valid_in & s_ready_out;
    assign rd          = valid & m_ready_in;

    // FSM: release rule for the head beat and cut-through entry/exit.
    always_comb begin
        state_d = state_q;
        valid   = 1'b0;
        unique case (state_q)
            ST_STORE: begin
                valid = !empty & ((pkt_count_q != '0) | full);
                // Only a full buffer with no complete packet can release a
                // non-last beat here: the packet is oversize, so keep draining.
                if (rd && !head.last && (pkt_count_q == '0))
                    state_d = ST_CUT;
            end
            ST_CUT: begin
                valid = !empty;
                if (rd && head.last)
                    state_d = ST_STORE;
            end
            default: state_d = ST_STORE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d    = rd ? rd_ptr_q + CW'(1) : rd_ptr_q;
        count_d     = count_q;
        pkt_count_d = pkt_count_q;
        unique case ({wr, rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        unique case ({wr & s_last_in, rd & head.last})
            2'b10:   pkt_count_d = pkt_count_q + CW'(1);
            2'b01:   pkt_count_d = pkt_count_q - CW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
            state_q     <= ST_STORE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            state_q     <= state_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr)
            mem_q[wr_ptr_q[AW-1:0]] <= beat_in;
    end

    assign m_valid_out   = valid;
    assign m_data_out    = valid ? head.data : '0;
    assign m_qos_out     = valid ? head.qos  : '0;
    assign m_id_out      = valid ? head.id   : '0;
    assign m_last_out    = valid ? head.last : 1'b0;
    assign count_out     = count_q;
    assign pkt_count_out = pkt_count_q;

endmodule

// File: tb/tb_stream_packet_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_packet_fifo
//
// Directed, table-driven bench. Each record holds one cycle of inputs and the
// outputs expected during that cycle (before the next rising edge). Inputs are
// driven on the falling edge and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_stream_packet_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] s_data_in;
    logic [1:0] s_qos_in;
    logic [1:0] s_id_in;
    logic       s_last_in;
    logic       s_valid_in;
    logic       s_ready_out;
    logic [3:0] m_data_out;
    logic [1:0] m_qos_out;
    logic [1:0] m_id_out;
    logic       m_last_out;
    logic       m_valid_out;
    logic       m_ready_in;
    logic [3:0] count_out;
    logic [3:0] pkt_count_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_packet_fifo #(
        .T_DATA_WIDTH(4), .T_QOS__WIDTH(2), .STREAM_COUNT(3), .DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data_in(s_data_in), .s_qos_in(s_qos_in), .s_id_in(s_id_in),
        .s_last_in(s_last_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
        .m_data_out(m_data_out), .m_qos_out(m_qos_out), .m_id_out(m_id_out),
        .m_last_out(m_last_out), .m_valid_out(m_valid_out), .m_ready_in(m_ready_in),
        .count_out(count_out), .pkt_count_out(pkt_count_out)
    );

    typedef struct {
        logic       rst, vld;
        logic [3:0] d;
        logic [1:0] q, id;
        logic       l, rdy;
        // expected
        logic       srdy, mv;
        logic [3:0] md;
        logic [1:0] mq, mi;
        logic       ml;
        logic [3:0] cnt, pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int r, input int v, input int d, input int q, input int i,
                       input int l, input int y, input int srdy, input int mv, input int md,
                       input int mq, input int mi, input int ml, input int c, input int p);
        vec_t x;
        x.rst = 1'(r);  x.vld = 1'(v);  x.d = 4'(d);  x.q = 2'(q);  x.id = 2'(i);
        x.l = 1'(l);    x.rdy = 1'(y);
        x.srdy = 1'(srdy); x.mv = 1'(mv); x.md = 4'(md); x.mq = 2'(mq); x.mi = 2'(mi);
        x.ml = 1'(ml);  x.cnt = 4'(c);  x.pc = 4'(p);
        vecs.push_back(x);
    endtask

    // idle cycle with consumer ready
    task automatic idle(input int srdy, input int mv, input int md, input int mq,
                        input int mi, input int ml, input int c, input int p);
        add(0, 0, 0, 0, 0, 0, 1, srdy, mv, md, mq, mi, ml, c, p);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_act();
        return 32'({s_ready_out, m_valid_out, m_data_out, m_qos_out, m_id_out,
                    m_last_out, count_out, pkt_count_out});
    endfunction

    initial begin
        // A: single-beat packet, 1-cycle latency
        add(0,1,5,2,1,1,1, 1,0,0,0,0,0,0,0);
        idle(1,1,5,2,1,1,1,1);
        idle(1,0,0,0,0,0,0,0);
        // B: three beats every other cycle; held until the last beat lands
        add(0,1,1,0,0,0,1, 1,0,0,0,0,0,0,0);
        idle(1,0,0,0,0,0,1,0);
        add(0,1,2,0,0,0,1, 1,0,0,0,0,0,1,0);
        idle(1,0,0,0,0,0,2,0);
        add(0,1,3,0,0,1,1, 1,0,0,0,0,0,2,0);
        idle(1,1,1,0,0,0,3,1);
        idle(1,1,2,0,0,0,2,1);
        idle(1,1,3,0,0,1,1,1);
        idle(1,0,0,0,0,0,0,0);
        // C: fill with eight one-beat packets, consumer stalled
        for (int i = 0; i < 8; i++)
            add(0,1,8+i,0,0,1,0, 1,(i!=0),(i!=0)?8:0,0,0,(i!=0),i,i);
        // full: read-only cycle, then write resumes
        add(0,1,0,1,2,1,1, 0,1,8,0,0,1,8,8);
        add(0,1,0,1,2,1,1, 1,1,9,0,0,1,7,7);
        for (int i = 0; i < 6; i++)
            idle(1,1,10+i,0,0,1,7-i,7-i);
        idle(1,1,0,1,2,1,1,1);
        idle(1,0,0,0,0,0,0,0);
        // D: ten-beat packet forces cut-through
        for (int k = 1; k <= 8; k++)
            add(0,1,k,3,1,0,1, 1,0,0,0,0,0,k-1,0);
        add(0,1,9,3,1,0,1, 0,1,1,3,1,0,8,0);
        add(0,1,9,3,1,0,1, 1,1,2,3,1,0,7,0);
        add(0,1,10,3,1,1,1, 1,1,3,3,1,0,7,0);
        for (int i = 0; i < 6; i++)
            idle(1,1,4+i,3,1,0,7-i,1);
        idle(1,1,10,3,1,1,1,1);
        idle(1,0,0,0,0,0,0,0);
        // back in store mode: a lone non-last beat must not be released
        add(0,1,1,0,0,0,1, 1,0,0,0,0,0,0,0);
        idle(1,0,0,0,0,0,1,0);
        add(0,1,2,0,0,1,1, 1,0,0,0,0,0,1,0);
        idle(1,1,1,0,0,0,2,1);
        idle(1,1,2,0,0,1,1,1);
        idle(1,0,0,0,0,0,0,0);
        // E: async reset mid-packet with three beats stored
        add(0,1,1,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,1,2,0,0,0,0, 1,0,0,0,0,0,1,0);
        add(0,1,3,0,0,0,0, 1,0,0,0,0,0,2,0);
        add(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,1,7,2,2,1,1, 1,0,0,0,0,0,0,0);
        idle(1,1,7,2,2,1,1,1);
        idle(1,0,0,0,0,0,0,0);
        // F: back-to-back packets with ids 0,2,1
        add(0,1,1,0,0,0,1, 1,0,0,0,0,0,0,0);
        add(0,1,2,0,0,1,1, 1,0,0,0,0,0,1,0);
        add(0,1,3,0,2,1,1, 1,1,1,0,0,0,2,1);
        add(0,1,4,0,1,0,1, 1,1,2,0,0,1,2,2);
        add(0,1,5,0,1,1,1, 1,1,3,0,2,1,2,1);
        idle(1,1,4,0,1,0,2,1);
        idle(1,1,5,0,1,1,1,1);
        idle(1,0,0,0,0,0,0,0);

        // reset state
        rst = 1'b1; s_valid_in = 1'b0; s_data_in = '0; s_qos_in = '0; s_id_in = '0;
        s_last_in = 1'b0; m_ready_in = 1'b0;
        #1;
        check("reset_state", -1, pack_act(), 32'({1'b1, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0}));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            s_valid_in = vecs[i].vld;
            s_data_in  = vecs[i].d;
            s_qos_in   = vecs[i].q;
            s_id_in    = vecs[i].id;
            s_last_in  = vecs[i].l;
            m_ready_in = vecs[i].rdy;
            #1;
            check("outputs", i, pack_act(),
                  32'({vecs[i].srdy, vecs[i].mv, vecs[i].md, vecs[i].mq, vecs[i].mi,
                       vecs[i].ml, vecs[i].cnt, vecs[i].pc}));
            check("pkt_le_count", i, 32'(pkt_count_out <= count_out), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
